wb_cpu_master: RTL and testbench

- Wishbone classic master front-end that sits directly upstream of the two-master Wishbone arbiter; one instance per CPU port (instruction fetch and load/store).
- Accepts a single-beat request from the pipeline on a valid/ready handshake and drives one Wishbone classic cycle.
- Waits for ack or err while the arbiter grants or stalls the cycle, then returns one response pulse to the pipeline.
- Guarantees at least one cycle of cyc low between transactions, so the arbiter always returns to idle and can re-arbitrate.

---
 rtl/wb_cpu_master.sv | 143 ++++++++++++++
 tb/tb_wb_cpu_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_master.sv
// Wishbone classic single-beat master front-end for one CPU port (fetch or load/store).
// Optional bus timeout abort is compiled in with `define WB_CPU_MASTER_TIMEOUT_EN.
module wb_cpu_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW/8-1:0]   i_be,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [DW-1:0]     o_rdata,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_adr,
    output logic [DW-1:0]     o_wb_dat,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_dat
);

    localparam int SW = DW / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            ready_en_q;
    logic            we_q;
    logic [AW-1:0]   adr_q;
    logic [DW-1:0]   dat_q;
    logic [SW-1:0]   sel_q;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            accept;
    logic            term;
    logic            tmo;

    // An out-of-range TIMEOUT leaves this empty block as an elaboration marker.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
    end

    assign accept = i_req && o_ready;
    assign term   = (state_q == BUS) && (i_wb_ack || i_wb_err || tmo);

`ifdef WB_CPU_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Abort on the edge where the count would reach TIMEOUT; a real response on that edge wins.
    assign tmo = (state_q == BUS) && !i_wb_ack && !i_wb_err && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if ((state_q == BUS) && !term) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Request capture needs no reset: it is only visible while in BUS.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            we_q  <= i_we;
            adr_q <= i_addr;
            dat_q <= i_wdata;
            sel_q <= i_be;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (term)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d  = term;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (term) begin
            err_d   = i_wb_err || tmo;
            rdata_d = (!we_q && i_wb_ack && !i_wb_err && !tmo) ? i_wb_dat : '0;
        end
    end

    always_comb begin
        o_ready  = (state_q == IDLE) && ready_en_q;
        o_wb_cyc = (state_q == BUS);
        o_wb_stb = (state_q == BUS);
        o_wb_we  = (state_q == BUS) && we_q;
        o_wb_adr = (state_q == BUS) ? adr_q : '0;
        o_wb_dat = (state_q == BUS) ? dat_q : '0;
        o_wb_sel = (state_q == BUS) ? sel_q : '0;
        o_done   = done_q;
        o_err    = err_q;
        o_rdata  = rdata_q;
    end

endmodule

// File: tb/tb_wb_cpu_master.sv
// Self-checking bench for wb_cpu_master: vector table, random transactions, corner sequences.
module tb_wb_cpu_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_we;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [3:0]    i_be;
    logic          o_ready, o_done, o_err;
    logic [DW-1:0] o_rdata;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          i_wb_ack, i_wb_err;
    logic [DW-1:0] i_wb_dat;

    always #5 clk = ~clk;

    wb_cpu_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_be(i_be),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic        ack;
        logic        err;
        logic [31:0] sdat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Response rules: error wins over ack; only an acked read returns data.
    function automatic void model(input vec_t v, output logic e, output logic [31:0] rd);
        e  = v.err;
        rd = (!v.we && v.ack && !v.err) ? v.sdat : 32'h0;
    endfunction

    task automatic run_txn(input vec_t v);
        i_req   = 1'b1;
        i_we    = v.we;
        i_addr  = v.addr;
        i_wdata = v.wdata;
        i_be    = v.be;
        chk("ready_idle", o_ready, 1);
        chk("cyc_idle", o_wb_cyc, 0);
        step;
        i_addr  = $urandom;
        i_wdata = $urandom;
        i_be    = 4'($urandom);
        i_we    = ~v.we;
        for (int w = 0; w <= v.waits; w++) begin
            chk("cyc_bus", o_wb_cyc, 1);
            chk("stb_bus", o_wb_stb, 1);
            chk("we_bus", o_wb_we, v.we);
            chk("adr_bus", o_wb_adr, v.addr);
            chk("dat_bus", o_wb_dat, v.wdata);
            chk("sel_bus", o_wb_sel, v.be);
            chk("ready_bus", o_ready, 0);
            chk("done_bus", o_done, 0);
            if (w == v.waits) begin
                i_wb_ack = v.ack;
                i_wb_err = v.err;
                i_wb_dat = v.sdat;
                i_req    = 1'b0;
            end else begin
                i_wb_dat = $urandom;
            end
            step;
        end
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        chk("done_pulse", o_done, 1);
        chk("err_resp", o_err, v.exp_err);
        chk("rdata_resp", o_rdata, v.exp_rdata);
        chk("cyc_after", o_wb_cyc, 0);
        chk("adr_after", o_wb_adr, 0);
        chk("sel_after", o_wb_sel, 0);
        chk("ready_after", o_ready, 1);
        step;
        chk("done_single", o_done, 0);
        chk("rdata_hold", o_rdata, v.exp_rdata);
    endtask

    vec_t tbl[6];
    vec_t rv;
    int   n;

    initial begin
        tbl[0] = '{1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 3, 1'b1, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h5555_5555, 32'h0, 4'hF, 0, 1'b1, 1'b1, 32'hABCD_0123, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h0000_3000, 32'h0, 4'hF, 1, 1'b0, 1'b1, 32'h1111_2222, 1'b1, 32'h0};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'b1100, 2, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'h0F0F_1234, 1'b0, 32'h0F0F_1234};

        rst = 1'b1;
        i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
        step;
        step;
        chk("rst_ready", o_ready, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        rst = 1'b0;
        chk("ready_before_edge", o_ready, 0);
        step;
        chk("ready_after_release", o_ready, 1);

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Back-to-back reads with i_req held: second accept lands in the first o_done cycle.
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0A00; i_be = 4'hF;
        step;
        chk("b2b_cyc1", o_wb_cyc, 1);
        chk("b2b_adr1", o_wb_adr, 32'h0000_0A00);
        i_addr = 32'h0000_0B00;
        i_wb_ack = 1'b1; i_wb_dat = 32'h1111_AAAA;
        step;
        i_wb_ack = 1'b0;
        chk("b2b_done1", o_done, 1);
        chk("b2b_rdata1", o_rdata, 32'h1111_AAAA);
        chk("b2b_gap", o_wb_cyc, 0);
        chk("b2b_ready_in_done", o_ready, 1);
        step;
        chk("b2b_cyc2", o_wb_cyc, 1);
        chk("b2b_adr2", o_wb_adr, 32'h0000_0B00);
        chk("b2b_done_low", o_done, 0);
        i_req = 1'b0;
        i_wb_ack = 1'b1; i_wb_dat = 32'h2222_BBBB;
        step;
        i_wb_ack = 1'b0;
        chk("b2b_done2", o_done, 1);
        chk("b2b_rdata2", o_rdata, 32'h2222_BBBB);
        step;

        for (int i = 0; i < 40; i++) begin
            rv.we    = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.be    = 4'($urandom);
            rv.waits = $urandom_range(0, TMO - 1);
            n        = $urandom_range(0, 2);
            rv.ack   = (n != 1);
            rv.err   = (n != 0);
            rv.sdat  = $urandom;
            model(rv, rv.exp_err, rv.exp_rdata);
            run_txn(rv);
        end

        // Reset two cycles into BUS: bus drops without an edge, no response follows.
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_4000; i_wdata = 32'h5A5A_5A5A; i_be = 4'hF;
        step;
        i_req = 1'b0;
        step;
        chk("rst_mid_cyc_before", o_wb_cyc, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_cyc", o_wb_cyc, 0);
        chk("rst_mid_stb", o_wb_stb, 0);
        chk("rst_mid_adr", o_wb_adr, 0);
        chk("rst_mid_ready", o_ready, 0);
        step;
        step;
        chk("rst_mid_done", o_done, 0);
        rst = 1'b0;
        chk("rst_mid_ready_held", o_ready, 0);
        step;
        chk("rst_mid_ready_edge", o_ready, 1);
        chk("rst_mid_no_done", o_done, 0);
        chk("rst_mid_no_cyc", o_wb_cyc, 0);

        // Silent slave.
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_5000; i_be = 4'hF;
        step;
        i_req = 1'b0;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
        n = 0;
        while (o_wb_cyc && n < 50) begin
            n++;
            step;
        end
        chk("tmo_cycles", 64'(n), 64'(TMO));
        chk("tmo_done", o_done, 1);
        chk("tmo_err", o_err, 1);
        chk("tmo_rdata", o_rdata, 0);
        step;
        chk("tmo_done_single", o_done, 0);
        rv = '{1'b0, 32'h0000_6000, 32'h0, 4'hF, TMO - 1, 1'b1, 1'b0, 32'h0000_600D, 1'b0, 32'h0000_600D};
        run_txn(rv);
`else
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (o_wb_cyc && !o_done) n++;
            step;
        end
        chk("no_tmo_cyc_held", 64'(n), 64'd100);
        chk("no_tmo_still_bus", o_wb_cyc, 1);
        i_wb_ack = 1'b1; i_wb_dat = 32'h7777_0001;
        step;
        i_wb_ack = 1'b0;
        chk("no_tmo_done", o_done, 1);
        chk("no_tmo_rdata", o_rdata, 32'h7777_0001);
        step;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
